median_window_11: RTL and testbench

Upstream feeder for the 11-input median sorting network. It accepts a 32-bit sample stream over a valid/ready handshake and keeps an 11-deep sliding window of the most recent samples. After priming, it presents each new window as eleven parallel words, one window per accepted sample. Its window outputs connect directly to the `data_0`..`data_10` inputs of the network.

---
 rtl/median_pkg.sv | 16 +
 rtl/median_shift_reg.sv | 30 +++
 rtl/median_window_11.sv | 105 ++++++++++
 tb/tb_median_window_11.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// median_pkg: shared types and constants for the median window feeder
// and the 11-input median sorting network it drives.
package median_pkg;

    localparam int unsigned MEDIAN_N = 11;
    localparam int unsigned MEDIAN_W = 32;

    typedef logic [31:0] data_t;
    typedef logic [3:0]  fill_t;

    // Saturating increment of the priming counter.
    function automatic fill_t fill_inc(input fill_t f, input fill_t max);
        return (f >= max) ? max : fill_t'(f + 4'd1);
    endfunction

endpackage

// File: rtl/median_shift_reg.sv
// median_shift_reg: N-slot sample shift register. Slot 0 is the oldest
// sample, slot N-1 the newest. A replicate load writes din into every
// slot at once and takes priority over a normal shift.
module median_shift_reg
    import median_pkg::*;
#(
    parameter int unsigned N = MEDIAN_N,
    parameter int unsigned W = MEDIAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         shift_en,
    input  logic         rep_en,
    input  logic [W-1:0] din,
    output logic [W-1:0] slot [N]
);

    // Window storage: replicate-fill, shift-in-newest, or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) slot[i] <= '0;
        end else if (rep_en) begin
            for (int unsigned i = 0; i < N; i++) slot[i] <= din;
        end else if (shift_en) begin
            for (int unsigned i = 0; i < N - 1; i++) slot[i] <= slot[i + 1];
            slot[N - 1] <= din;
        end
    end

endmodule

// File: rtl/median_window_11.sv
// median_window_11: 11-deep sliding-window feeder for the median sorting
// network. Accepts a sample stream over valid/ready and presents one full
// window per accepted sample once primed.
// Optional feature: MEDIAN_WIN_EDGE_REPLICATE_EN -- first accept after
// reset/clear fills every slot with that sample so windows start at once.
module median_window_11
    import median_pkg::*;
#(
    parameter int unsigned N = MEDIAN_N,
    parameter int unsigned W = MEDIAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         win_valid,
    input  logic         win_ready,
    output logic [W-1:0] win_data_0,
    output logic [W-1:0] win_data_1,
    output logic [W-1:0] win_data_2,
    output logic [W-1:0] win_data_3,
    output logic [W-1:0] win_data_4,
    output logic [W-1:0] win_data_5,
    output logic [W-1:0] win_data_6,
    output logic [W-1:0] win_data_7,
    output logic [W-1:0] win_data_8,
    output logic [W-1:0] win_data_9,
    output logic [W-1:0] win_data_10,
    output logic         primed
);

    localparam fill_t FILL_MAX = fill_t'(N);

    logic         accept;
    logic         rep_load;
    fill_t        fill_q;
    fill_t        fill_d;
    logic         valid_d;
    logic [W-1:0] slot [N];

    // A consumed window frees the output slot in the same cycle.
    assign in_ready = !clear && (!win_valid || win_ready);
    assign accept   = in_valid && in_ready;
    assign primed   = (fill_q == FILL_MAX);

`ifdef MEDIAN_WIN_EDGE_REPLICATE_EN
    assign rep_load = accept && (fill_q == '0);
`else
    assign rep_load = 1'b0;
`endif

    // Next fill count and window-valid; clear dominates, then a completed
    // window, then consumption.
    always_comb begin
        fill_d  = fill_q;
        valid_d = win_valid;
        if (clear) begin
            fill_d  = '0;
            valid_d = 1'b0;
        end else begin
            if (rep_load)    fill_d = FILL_MAX;
            else if (accept) fill_d = fill_inc(fill_q, FILL_MAX);
            if (accept && (fill_d == FILL_MAX)) valid_d = 1'b1;
            else if (win_valid && win_ready)    valid_d = 1'b0;
        end
    end

    // Handshake and priming state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q    <= '0;
            win_valid <= 1'b0;
        end else begin
            fill_q    <= fill_d;
            win_valid <= valid_d;
        end
    end

    median_shift_reg #(
        .N (N),
        .W (W)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (accept && !rep_load),
        .rep_en   (rep_load),
        .din      (in_data),
        .slot     (slot)
    );

    assign win_data_0  = slot[0];
    assign win_data_1  = slot[1];
    assign win_data_2  = slot[2];
    assign win_data_3  = slot[3];
    assign win_data_4  = slot[4];
    assign win_data_5  = slot[5];
    assign win_data_6  = slot[6];
    assign win_data_7  = slot[7];
    assign win_data_8  = slot[8];
    assign win_data_9  = slot[9];
    assign win_data_10 = slot[10];

endmodule

// File: tb/tb_median_window_11.sv
// tb_median_window_11: scoreboard bench for median_window_11. Expected
// windows are pushed when the bench model sees a completing accept and
// popped when the window is consumed. Honours MEDIAN_WIN_EDGE_REPLICATE_EN.
module tb_median_window_11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        win_valid;
    logic        win_ready = 1'b0;
    logic [31:0] wd0, wd1, wd2, wd3, wd4, wd5, wd6, wd7, wd8, wd9, wd10;
    logic        primed;
    logic [351:0] dut_win;

    median_window_11 #(.N(11), .W(32)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .win_valid(win_valid), .win_ready(win_ready),
        .win_data_0(wd0), .win_data_1(wd1), .win_data_2(wd2), .win_data_3(wd3),
        .win_data_4(wd4), .win_data_5(wd5), .win_data_6(wd6), .win_data_7(wd7),
        .win_data_8(wd8), .win_data_9(wd9), .win_data_10(wd10),
        .primed(primed)
    );

    assign dut_win = {wd10, wd9, wd8, wd7, wd6, wd5, wd4, wd3, wd2, wd1, wd0};

    always #5 clk = ~clk;

    // Bench model: slot i lives at m_win[i*32 +: 32]
    logic [351:0] m_win = '0;
    int           m_fill = 0;
    logic         m_valid = 1'b0;
    logic [351:0] sb [$];
    int           nchk = 0;
    int           nerr = 0;
    logic         exp_rdy;

    task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic c);
        in_valid  = v;
        in_data   = d;
        win_ready = r;
        clear     = c;
        exp_rdy   = !c && (!m_valid || r);
        @(negedge clk);
    endtask

    task automatic model_tick();
        logic acc;
        acc = in_valid && exp_rdy;
        @(posedge clk);
        if (clear) begin
            m_fill = 0;
            m_valid = 1'b0;
            sb.delete();
        end else begin
            if (m_valid && win_ready && sb.size() > 0) void'(sb.pop_front());
            if (acc) begin
`ifdef MEDIAN_WIN_EDGE_REPLICATE_EN
                if (m_fill == 0) begin
                    m_win  = {11{in_data}};
                    m_fill = 11;
                end else
`endif
                begin
                    m_win = {in_data, m_win[351:32]};
                    if (m_fill < 11) m_fill++;
                end
                if (m_fill == 11) begin
                    sb.push_back(m_win);
                    m_valid = 1'b1;
                end
            end else if (m_valid && win_ready) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic model_reset();
        m_win = '0;
        m_fill = 0;
        m_valid = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        nchk++; if (win_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %0b want 0", win_valid); end
        nchk++; if (primed !== 1'b0) begin nerr++; $display("FAIL reset_primed got %0b want 0", primed); end
        nchk++; if (dut_win !== '0) begin nerr++; $display("FAIL reset_window got %h want 0", dut_win); end
        nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready got %0b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL post_reset_ready got %0b want 1", in_ready); end
    endtask

    // Samples 1..13 with the consumer always ready, then one idle cycle
    task automatic test_stream();
        for (int unsigned k = 1; k <= 14; k++) begin
            drive(k <= 13, 32'(k), 1'b1, 1'b0);
            nchk++; if (in_ready !== exp_rdy) begin nerr++; $display("FAIL stream_ready k=%0d got %0b want %0b", k, in_ready, exp_rdy); end
            nchk++; if (win_valid !== m_valid) begin nerr++; $display("FAIL stream_valid k=%0d got %0b want %0b", k, win_valid, m_valid); end
            nchk++; if (primed !== (m_fill == 11)) begin nerr++; $display("FAIL stream_primed k=%0d got %0b want %0b", k, primed, m_fill == 11); end
            if (m_valid) begin
                nchk++; if (sb.size() == 0 || dut_win !== sb[0]) begin nerr++; $display("FAIL stream_window k=%0d got %h want %h", k, dut_win, sb.size() ? sb[0] : '0); end
            end
`ifndef MEDIAN_WIN_EDGE_REPLICATE_EN
            if (k == 12) begin
                nchk++; if (wd0 !== 32'd1 || wd10 !== 32'd11) begin nerr++; $display("FAIL first_window got %0d..%0d want 1..11", wd0, wd10); end
            end
            if (k == 11) begin
                nchk++; if (win_valid !== 1'b0) begin nerr++; $display("FAIL early_valid got %0b want 0", win_valid); end
            end
`endif
            model_tick();
        end
    endtask

    // Prime, then hold the consumer off for 3 cycles with a sample pending
    task automatic test_backpressure();
        for (int unsigned k = 0; k < 16; k++) begin
            drive(1'b1, 32'(100 + k), !(k >= 11 && k <= 13), 1'b0);
            nchk++; if (in_ready !== exp_rdy) begin nerr++; $display("FAIL bp_ready k=%0d got %0b want %0b", k, in_ready, exp_rdy); end
            nchk++; if (win_valid !== m_valid) begin nerr++; $display("FAIL bp_valid k=%0d got %0b want %0b", k, win_valid, m_valid); end
            if (m_valid) begin
                nchk++; if (sb.size() == 0 || dut_win !== sb[0]) begin nerr++; $display("FAIL bp_window k=%0d got %h want %h", k, dut_win, sb.size() ? sb[0] : '0); end
            end
            if (k >= 12 && k <= 13) begin
                nchk++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_stall_ready k=%0d got %0b want 0", k, in_ready); end
            end
            model_tick();
        end
    endtask

    // Clear on the cycle sample 20 is offered, then re-prime with 11 samples
    task automatic test_clear();
        for (int unsigned k = 0; k < 14; k++) begin
            drive(1'b1, (k == 0) ? 32'd20 : 32'(200 + k), 1'b1, k == 0);
            nchk++; if (in_ready !== exp_rdy) begin nerr++; $display("FAIL clr_ready k=%0d got %0b want %0b", k, in_ready, exp_rdy); end
            nchk++; if (win_valid !== m_valid) begin nerr++; $display("FAIL clr_valid k=%0d got %0b want %0b", k, win_valid, m_valid); end
            nchk++; if (primed !== (m_fill == 11)) begin nerr++; $display("FAIL clr_primed k=%0d got %0b want %0b", k, primed, m_fill == 11); end
            if (m_valid) begin
                nchk++; if (sb.size() == 0 || dut_win !== sb[0]) begin nerr++; $display("FAIL clr_window k=%0d got %h want %h", k, dut_win, sb.size() ? sb[0] : '0); end
            end
            model_tick();
        end
    endtask

    // Asynchronous reset while a window is held, then re-prime
    task automatic test_async_reset();
        drive(1'b0, '0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        nchk++; if (win_valid !== 1'b0 || primed !== 1'b0) begin nerr++; $display("FAIL areset_flags got v=%0b p=%0b want 0 0", win_valid, primed); end
        nchk++; if (dut_win !== '0) begin nerr++; $display("FAIL areset_window got %h want 0", dut_win); end
        nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL areset_ready got %0b want 1", in_ready); end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int unsigned k = 0; k < 12; k++) begin
            drive(k < 11, 32'(300 + k), 1'b1, 1'b0);
            nchk++; if (in_ready !== exp_rdy) begin nerr++; $display("FAIL ar_ready k=%0d got %0b want %0b", k, in_ready, exp_rdy); end
            nchk++; if (win_valid !== m_valid) begin nerr++; $display("FAIL ar_valid k=%0d got %0b want %0b", k, win_valid, m_valid); end
            if (m_valid) begin
                nchk++; if (sb.size() == 0 || dut_win !== sb[0]) begin nerr++; $display("FAIL ar_window k=%0d got %h want %h", k, dut_win, sb.size() ? sb[0] : '0); end
            end
            model_tick();
        end
    endtask

`ifdef MEDIAN_WIN_EDGE_REPLICATE_EN
    task automatic test_replicate();
        drive(1'b0, '0, 1'b1, 1'b1);
        model_tick();
        drive(1'b1, 32'h0000_00AA, 1'b1, 1'b0);
        model_tick();
        drive(1'b1, 32'h0000_00BB, 1'b1, 1'b0);
        nchk++; if (win_valid !== 1'b1) begin nerr++; $display("FAIL rep_valid got %0b want 1", win_valid); end
        nchk++; if (dut_win !== {11{32'h0000_00AA}}) begin nerr++; $display("FAIL rep_first got %h want all AA", dut_win); end
        model_tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        nchk++; if (dut_win !== {32'h0000_00BB, {10{32'h0000_00AA}}}) begin nerr++; $display("FAIL rep_second got %h want BB then AA", dut_win); end
        nchk++; if (sb.size() == 0 || dut_win !== sb[0]) begin nerr++; $display("FAIL rep_scoreboard got %h want %h", dut_win, sb.size() ? sb[0] : '0); end
        model_tick();
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_clear();
        test_async_reset();
`ifdef MEDIAN_WIN_EDGE_REPLICATE_EN
        test_replicate();
`endif
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
